// File: rtl/video_mode_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// video_mode_sequencer_pkg
// Purpose : Shared types and constants for the video mode sequencer.
//           - Mode codes that the switch-decode stage produces.
//           - Sequencer state encoding (3 bits).
//           - Saturating increment helper for the 4-bit retry counter.
// Ports   : none (package).
// Config  : the MODE_SEQ_TIMEOUT_EN macro is consumed by video_mode_sequencer,
//           not by this package.
// ----------------------------------------------------------------------------
package video_mode_sequencer_pkg;

  // Mode codes driven on config_data by the switch-decode stage.
  localparam logic [7:0] Mode480i  = 8'h00;
  localparam logic [7:0] Mode480p  = 8'h01;
  localparam logic [7:0] Mode720p  = 8'h02;
  localparam logic [7:0] Mode1080i = 8'h03;
  localparam logic [7:0] Mode1080p = 8'h04;

  // Sequencer states.
  typedef enum logic [2:0] {
    StQuiesce    = 3'd0,
    StReconfReq  = 3'd1,
    StReconfWait = 3'd2,
    StWaitLock   = 3'd3,
    StRelease    = 3'd4,
    StRunning    = 3'd5
  } vms_state_e;

  // Saturating increment for the 4-bit retry counter (holds at 15).
  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/video_mode_sequencer_lock_stable_filter.sv
// ----------------------------------------------------------------------------
// video_mode_sequencer_lock_stable_filter
// Purpose : Counts consecutive cycles of i_locked=1. Any cycle with i_locked=0
//           clears the count. The count saturates at LOCK_STABLE and o_stable
//           is high while the count sits there.
// Ports   :
//   i_clock    in  1  system clock
//   i_reset_n  in  1  synchronous active-low reset
//   i_clear    in  1  holds the count at zero (asserted by the sequencer outside
//                     its lock-wait state, so every entry starts from zero)
//   i_locked   in  1  PLL lock, already synchronised to i_clock
//   o_stable   out 1  level: LOCK_STABLE consecutive locked cycles observed
// ----------------------------------------------------------------------------
module video_mode_sequencer_lock_stable_filter #(
  parameter int unsigned LOCK_STABLE = 1024
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_locked,
  output logic o_stable
);

  localparam int unsigned CntW = $clog2(LOCK_STABLE + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(LOCK_STABLE);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clear || !i_locked) begin
      w_cnt_next = '0;
    end else if (r_cnt != CntMax) begin
      w_cnt_next = r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_stable = (r_cnt == CntMax);

endmodule

// File: rtl/video_mode_sequencer.sv
// ----------------------------------------------------------------------------
// video_mode_sequencer
// Purpose : Sequences a safe video mode change: hold the video path in reset,
//           reprogram the pixel PLL through a start/busy handshake, wait for
//           a stable lock, then release the video path.
// Ports   :
//   i_clock           in  1  system clock
//   i_reset_n         in  1  synchronous active-low reset
//   i_config_data     in  8  requested mode code
//   i_config_changed  in  1  1-cycle pulse: config_data changed
//   i_pll_busy        in  1  PLL reconfig controller busy
//   i_pll_locked      in  1  pixel PLL lock (synchronised)
//   o_pll_start       out 1  1-cycle reconfig request
//   o_pll_mode        out 8  mode to program; stable from start until busy falls
//   o_video_reset     out 1  active-high reset to timing generator/output path
//   o_active_mode     out 8  mode currently driven by the video path
//   o_mode_ready      out 1  high while running
//   o_retry_count     out 4  saturating timeout retry count (0 when disabled)
// Config  : `MODE_SEQ_TIMEOUT_EN enables a timeout over the busy/lock waits
//           (parameter RECONF_TIMEOUT) and the retry counter. Without it the
//           sequencer waits indefinitely and o_retry_count is tied to 0.
// ----------------------------------------------------------------------------
module video_mode_sequencer
  import video_mode_sequencer_pkg::*;
#(
  parameter int unsigned QUIESCE_CYCLES = 16,
  parameter int unsigned LOCK_STABLE    = 1024
`ifdef MODE_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned RECONF_TIMEOUT = 1000000
`endif
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [7:0] i_config_data,
  input  logic       i_config_changed,
  input  logic       i_pll_busy,
  input  logic       i_pll_locked,
  output logic       o_pll_start,
  output logic [7:0] o_pll_mode,
  output logic       o_video_reset,
  output logic [7:0] o_active_mode,
  output logic       o_mode_ready,
  output logic [3:0] o_retry_count
);

  localparam int unsigned QCntW = $clog2(QUIESCE_CYCLES + 1);
  localparam logic [QCntW-1:0] QLast = QCntW'(QUIESCE_CYCLES - 1);

  vms_state_e       r_state,       w_state_next;
  logic [7:0]       r_target,      w_target_next;
  logic [7:0]       r_pll_mode,    w_pll_mode_next;
  logic             r_video_reset, w_video_reset_next;
  logic [7:0]       r_active_mode, w_active_mode_next;
  logic             r_pending,     w_pending_next;
  logic [QCntW-1:0] r_q_cnt,       w_q_cnt_next;
  logic             r_busy_seen,   w_busy_seen_next;
  logic             w_pll_start;
  logic             w_mode_ready;
  logic             w_lock_stable;
  logic             w_lock_clear;
  logic             w_timeout;

  // Lock filter only counts inside the lock-wait state; outside it is held clear
  // so each entry starts a fresh stability window.
  assign w_lock_clear = (r_state != StWaitLock);

  video_mode_sequencer_lock_stable_filter #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_filter (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (w_lock_clear),
    .i_locked  (i_pll_locked),
    .o_stable  (w_lock_stable)
  );

`ifdef MODE_SEQ_TIMEOUT_EN
  localparam int unsigned TCntW = $clog2(RECONF_TIMEOUT + 1);
  localparam logic [TCntW-1:0] TLast = TCntW'(RECONF_TIMEOUT - 1);

  logic [TCntW-1:0] r_to_cnt, w_to_cnt_next;
  logic [3:0]       r_retry,  w_retry_next;

  // One budget covers both the busy wait and the lock wait.
  always_comb begin
    w_to_cnt_next = '0;
    w_retry_next  = r_retry;
    w_timeout     = 1'b0;
    if (r_state == StReconfWait || r_state == StWaitLock) begin
      if (r_to_cnt == TLast) begin
        w_timeout    = 1'b1;
        w_retry_next = sat_inc4(r_retry);
      end else begin
        w_to_cnt_next = r_to_cnt + TCntW'(1);
      end
    end
  end

  // Retry count survives timeouts and mode changes; only reset clears it.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_to_cnt <= '0;
      r_retry  <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_next;
      r_retry  <= w_retry_next;
    end
  end

  assign o_retry_count = r_retry;
`else
  assign w_timeout     = 1'b0;
  assign o_retry_count = 4'd0;
`endif

  // Next-state and output decode.
  always_comb begin
    w_state_next       = r_state;
    w_target_next      = r_target;
    w_pll_mode_next    = r_pll_mode;
    w_video_reset_next = r_video_reset;
    w_active_mode_next = r_active_mode;
    w_pending_next     = r_pending;
    w_q_cnt_next       = '0;
    w_busy_seen_next   = 1'b0;
    w_pll_start        = 1'b0;
    w_mode_ready       = 1'b0;

    unique case (r_state)
      StQuiesce: begin
        w_video_reset_next = 1'b1;
        if (i_config_changed) begin
          // A new request restarts the quiet period with the new target.
          w_target_next = i_config_data;
        end else if (r_q_cnt == QLast) begin
          // pll_mode is loaded here so it is already valid during the start pulse.
          w_pll_mode_next = r_target;
          w_state_next    = StReconfReq;
        end else begin
          w_q_cnt_next = r_q_cnt + QCntW'(1);
        end
      end

      StReconfReq: begin
        w_pll_start  = 1'b1;
        w_state_next = StReconfWait;
        if (i_config_changed) begin
          w_pending_next = 1'b1;
        end
      end

      StReconfWait: begin
        if (i_config_changed) begin
          w_pending_next = 1'b1;
        end
        // Busy must be seen high before its fall counts as completion.
        if (i_pll_busy) begin
          w_busy_seen_next = 1'b1;
        end else if (r_busy_seen) begin
          w_state_next = StWaitLock;
        end else begin
          w_busy_seen_next = r_busy_seen;
        end
      end

      StWaitLock: begin
        if (i_config_changed) begin
          w_pending_next = 1'b1;
        end
        if (w_lock_stable) begin
          w_state_next = StRelease;
        end
      end

      StRelease: begin
        if (r_pending || i_config_changed) begin
          // A request arrived mid-sequence: run another full sequence.
          w_pending_next = 1'b0;
          w_target_next  = i_config_data;
          w_state_next   = StQuiesce;
        end else begin
          w_active_mode_next = r_target;
          w_video_reset_next = 1'b0;
          w_state_next       = StRunning;
        end
      end

      StRunning: begin
        w_mode_ready = 1'b1;
        if (i_config_changed || (i_config_data != r_active_mode)) begin
          w_target_next      = i_config_data;
          w_video_reset_next = 1'b1;
          w_state_next       = StQuiesce;
        end else if (!i_pll_locked) begin
          // Lost lock: re-sequence with the same target.
          w_video_reset_next = 1'b1;
          w_state_next       = StQuiesce;
        end
      end

      default: begin
        w_video_reset_next = 1'b1;
        w_state_next       = StQuiesce;
      end
    endcase

    // Timeout overrides the wait states; the target is kept for the retry.
    if (w_timeout) begin
      w_busy_seen_next   = 1'b0;
      w_video_reset_next = 1'b1;
      w_state_next       = StQuiesce;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state       <= StQuiesce;
      r_target      <= i_config_data;
      r_pll_mode    <= i_config_data;
      r_video_reset <= 1'b1;
      r_active_mode <= Mode1080p;
      r_pending     <= 1'b0;
      r_q_cnt       <= '0;
      r_busy_seen   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_target      <= w_target_next;
      r_pll_mode    <= w_pll_mode_next;
      r_video_reset <= w_video_reset_next;
      r_active_mode <= w_active_mode_next;
      r_pending     <= w_pending_next;
      r_q_cnt       <= w_q_cnt_next;
      r_busy_seen   <= w_busy_seen_next;
    end
  end

  assign o_pll_start   = w_pll_start;
  assign o_pll_mode    = r_pll_mode;
  assign o_video_reset = r_video_reset;
  assign o_active_mode = r_active_mode;
  assign o_mode_ready  = w_mode_ready;

endmodule

// File: tb/tb_video_mode_sequencer.sv
`timescale 1ns/1ps
module tb_video_mode_sequencer;
  import video_mode_sequencer_pkg::*;

  localparam int unsigned LockStable = 1024;
  // Negedges from the lock rising (BFM) to mode_ready seen: LOCK_STABLE counted
  // cycles, one cycle to reach RELEASE, one to reach RUNNING.
  localparam int LockToReady = LockStable + 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] cfg_data;
  logic       cfg_changed;
  logic       pll_busy   = 1'b0;
  logic       bfm_locked = 1'b0;
  logic       lock_kill;
  logic       pll_locked;
  logic       pll_start;
  logic [7:0] pll_mode;
  logic       video_reset;
  logic [7:0] active_mode;
  logic       mode_ready;
  logic [3:0] retry_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_count = 0;
  int lock_rise_cyc = 0;
  int busy_left = 0;
  int lock_wait = 0;
  bit bfm_hang = 1'b0;

  assign pll_locked = bfm_locked & ~lock_kill;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  video_mode_sequencer #(
    .QUIESCE_CYCLES (16),
    .LOCK_STABLE    (LockStable)
`ifdef MODE_SEQ_TIMEOUT_EN
    ,
    .RECONF_TIMEOUT (100)
`endif
  ) dut (
    .i_clock          (clk),
    .i_reset_n        (reset_n),
    .i_config_data    (cfg_data),
    .i_config_changed (cfg_changed),
    .i_pll_busy       (pll_busy),
    .i_pll_locked     (pll_locked),
    .o_pll_start      (pll_start),
    .o_pll_mode       (pll_mode),
    .o_video_reset    (video_reset),
    .o_active_mode    (active_mode),
    .o_mode_ready     (mode_ready),
    .o_retry_count    (retry_count)
  );

  // PLL reconfig BFM: busy for 20 cycles after start, lock 50 cycles after busy falls.
  always @(negedge clk) begin
    if (pll_start) begin
      start_count++;
      pll_busy   = 1'b1;
      bfm_locked = 1'b0;
      busy_left  = 20;
      lock_wait  = 0;
    end else if (pll_busy) begin
      if (!bfm_hang) begin
        busy_left--;
        if (busy_left == 0) begin
          pll_busy  = 1'b0;
          lock_wait = 50;
        end
      end
    end else if (lock_wait > 0) begin
      lock_wait--;
      if (lock_wait == 0) begin
        bfm_locked    = 1'b1;
        lock_rise_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!mode_ready && n < budget) begin
      tick();
      n++;
    end
    chk({tag, " ready"}, 32'(mode_ready), 32'd1);
  endtask

  task automatic change_mode(input string tag, input logic [7:0] m);
    cfg_data    = m;
    cfg_changed = 1'b1;
    tick();
    cfg_changed = 1'b0;
    chk({tag, " vreset"}, 32'(video_reset), 32'd1);
    chk({tag, " not ready"}, 32'(mode_ready), 32'd0);
  endtask

  initial begin
    int s0;
    int c0;
    int n;
    reset_n     = 1'b0;
    cfg_data    = Mode720p;
    cfg_changed = 1'b0;
    lock_kill   = 1'b0;
`ifdef MODE_SEQ_TIMEOUT_EN
    bfm_hang    = 1'b1;
`endif
    repeat (3) tick();

    // Reset state
    chk("rst vreset", 32'(video_reset), 32'd1);
    chk("rst start", 32'(pll_start), 32'd0);
    chk("rst ready", 32'(mode_ready), 32'd0);
    chk("rst active", 32'(active_mode), 32'(Mode1080p));
    chk("rst pllmode", 32'(pll_mode), 32'(Mode720p));
    chk("rst retry", 32'(retry_count), 32'd0);
    reset_n = 1'b1;

`ifdef MODE_SEQ_TIMEOUT_EN
    // Busy never falls: retries every 16 + 1 + 100 cycles, saturating at 15.
    n = 0;
    while (retry_count != 4'd1 && n < 500) begin tick(); n++; end
    chk("to retry1", 32'(retry_count), 32'd1);
    c0 = cyc;
    n = 0;
    while (retry_count != 4'd2 && n < 500) begin tick(); n++; end
    chk("to retry2", 32'(retry_count), 32'd2);
    chk("to period", 32'(cyc - c0), 32'd117);
    repeat (20 * 117) tick();
    chk("to sat", 32'(retry_count), 32'd15);
    n = 0;
    while (!pll_start && n < 500) begin tick(); n++; end
    chk("to start seen", 32'(pll_start), 32'd1);
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    chk("to rst retry", 32'(retry_count), 32'd0);
    chk("to rst vreset", 32'(video_reset), 32'd1);
    chk("to rst start", 32'(pll_start), 32'd0);
    chk("to rst ready", 32'(mode_ready), 32'd0);
    chk("to rst active", 32'(active_mode), 32'(Mode1080p));
    chk("to rst pllmode", 32'(pll_mode), 32'(Mode720p));
    reset_n = 1'b1;
`else
    // 1: first configuration after reset
    wait_ready("t1", 3000);
    chk("t1 starts", 32'(start_count), 32'd1);
    chk("t1 pllmode", 32'(pll_mode), 32'(Mode720p));
    chk("t1 active", 32'(active_mode), 32'(Mode720p));
    chk("t1 vreset", 32'(video_reset), 32'd0);
    chk("t1 latency", 32'(cyc - lock_rise_cyc), 32'(LockToReady));

    // 2: 720p -> 1080p -> 480p
    change_mode("t2a", Mode1080p);
    wait_ready("t2a", 3000);
    chk("t2a active", 32'(active_mode), 32'(Mode1080p));
    s0 = start_count;
    change_mode("t2b", Mode480p);
    wait_ready("t2b", 3000);
    chk("t2b starts", 32'(start_count - s0), 32'd1);
    chk("t2b pllmode", 32'(pll_mode), 32'(Mode480p));
    chk("t2b active", 32'(active_mode), 32'(Mode480p));

    // 3: request 480i while the 720p sequence is in WAIT_LOCK
    s0 = start_count;
    change_mode("t3a", Mode720p);
    n = 0;
    while (!(start_count == s0 + 1 && !pll_busy) && n < 500) begin tick(); n++; end
    chk("t3 busy done", 32'(start_count - s0), 32'd1);
    repeat (100) tick();
    change_mode("t3b", Mode480i);
    wait_ready("t3", 5000);
    chk("t3 starts", 32'(start_count - s0), 32'd2);
    chk("t3 pllmode", 32'(pll_mode), 32'(Mode480i));
    chk("t3 active", 32'(active_mode), 32'(Mode480i));

    // 4: 3-cycle lock drop at stability count 500
    s0 = start_count;
    change_mode("t4", Mode720p);
    n = 0;
    while (!(start_count == s0 + 1 && bfm_locked) && n < 500) begin tick(); n++; end
    chk("t4 locked", 32'(bfm_locked), 32'd1);
    repeat (500) tick();
    lock_kill = 1'b1;
    repeat (3) tick();
    lock_kill = 1'b0;
    c0 = cyc;
    wait_ready("t4", 3000);
    chk("t4 latency", 32'(cyc - c0), 32'(LockToReady));
    chk("t4 active", 32'(active_mode), 32'(Mode720p));

    // Idle in RUNNING: no spurious starts
    s0 = start_count;
    repeat (50) tick();
    chk("idle starts", 32'(start_count - s0), 32'd0);
    chk("idle ready", 32'(mode_ready), 32'd1);

    // 5: 1-cycle lock loss in RUNNING -> relock with same mode
    lock_kill = 1'b1;
    tick();
    lock_kill = 1'b0;
    chk("t5 vreset", 32'(video_reset), 32'd1);
    chk("t5 not ready", 32'(mode_ready), 32'd0);
    wait_ready("t5", 3000);
    chk("t5 starts", 32'(start_count - s0), 32'd1);
    chk("t5 pllmode", 32'(pll_mode), 32'(Mode720p));
    chk("t5 active", 32'(active_mode), 32'(Mode720p));

    // 7: reset while waiting on busy
    s0 = start_count;
    change_mode("t7", Mode1080i);
    n = 0;
    while (start_count == s0 && n < 500) begin tick(); n++; end
    repeat (5) tick();
    chk("t7 busy", 32'(pll_busy), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("t7 rst vreset", 32'(video_reset), 32'd1);
    chk("t7 rst start", 32'(pll_start), 32'd0);
    chk("t7 rst ready", 32'(mode_ready), 32'd0);
    chk("t7 rst active", 32'(active_mode), 32'(Mode1080p));
    chk("t7 rst pllmode", 32'(pll_mode), 32'(Mode1080i));
    chk("t7 rst retry", 32'(retry_count), 32'd0);
    reset_n = 1'b1;
    wait_ready("t7", 3000);
    chk("t7 active", 32'(active_mode), 32'(Mode1080i));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
